// File: rtl/ifu.sv
// ============================================================================
//  Module   : ifu
//  Purpose  : Instruction fetch unit. Streams sequential instruction words
//             from the instruction SRAM into the IDU through a small
//             prefetch FIFO. Fetching starts at start_pc and stops once the
//             IDU reports a WFI instruction.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu #(
  parameter int ADDR_W     = 12,
  parameter int INS_W      = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic              ifu_imem_req,
  output logic [ADDR_W-1:0] ifu_imem_addr,
  input  logic [INS_W-1:0]  imem_ifu_rdata,
  input  logic              idu_ifu_rdy,
  input  logic              idu_ifu_wfi,
  output logic              ifu_idu_vld,
  output logic [INS_W-1:0]  ifu_idu_ins,
  output logic              ifu_busy,
  output logic              ifu_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [INS_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              rd_pend;

  logic              fetching;
  logic              launch;
  logic              flush;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    occupancy;

  // Pointer advance that also works for non power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fetching  = (state == FETCH);
  // A start pulse is only honoured outside FETCH.
  assign launch    = (state != FETCH) & start;
  // WFI seen while fetching: leave FETCH and throw away everything prefetched.
  assign flush     = fetching & idu_ifu_wfi;

  // The WFI mask keeps the IDU from taking anything queued behind the WFI.
  assign ifu_idu_vld = (count != '0) & fetching & ~idu_ifu_wfi;
  assign pop         = ifu_idu_vld & idu_ifu_rdy;
  // Returning data lands in the FIFO unless the flush discards it.
  assign push        = rd_pend & ~flush;

  // Slots already claimed after this cycle's pop; a new read may only be
  // issued when its data is guaranteed a free FIFO entry on return.
  assign occupancy    = {1'b0, count} + (CNT_W + 1)'(rd_pend) - (CNT_W + 1)'(pop);
  assign ifu_imem_req = fetching & ~idu_ifu_wfi & (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign ifu_imem_addr = pc;

  // Empty FIFO presents zero so the instruction bus is quiet out of reset.
  assign ifu_idu_ins = (count != '0) ? fifo_mem[rd_ptr] : '0;
  assign ifu_busy    = fetching;
  assign ifu_done    = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = FETCH;
      FETCH:   if (idu_ifu_wfi) state_nxt = DONE;
      DONE:    if (start)       state_nxt = FETCH;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Fetch PC, read-pending flag and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      rd_pend <= 1'b0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      if (launch) begin
        pc <= start_pc;
      end else if (ifu_imem_req) begin
        pc <= pc + 1'b1;
      end

      if (flush) begin
        rd_pend <= 1'b0;
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
      end else begin
        rd_pend <= ifu_imem_req;
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= imem_ifu_rdata;
    end
  end

  // The issue rule must never let a return arrive at a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CNT_W'(FIFO_DEPTH))));

endmodule

`default_nettype wire

// File: tb/tb_ifu.sv
// ============================================================================
//  Module   : tb_ifu
//  Purpose  : Self-checking bench for ifu. A table of fetch runs plus random
//             runs are checked against a queue-based model of the fetch
//             stream; hand sequences cover reset and start-while-fetching.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu;

  localparam int ADDR_W = 12;
  localparam int INS_W  = 64;
  localparam int DEPTH  = 2;
  localparam int M_ALL  = 0;
  localparam int M_RAND = 1;
  localparam int M_STALL = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_pc;
  logic              ifu_imem_req;
  logic [ADDR_W-1:0] ifu_imem_addr;
  logic [INS_W-1:0]  imem_ifu_rdata;
  logic              idu_ifu_rdy;
  logic              idu_ifu_wfi;
  logic              ifu_idu_vld;
  logic [INS_W-1:0]  ifu_idu_ins;
  logic              ifu_busy;
  logic              ifu_done;

  ifu #(.ADDR_W(ADDR_W), .INS_W(INS_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_pc       (start_pc),
    .ifu_imem_req   (ifu_imem_req),
    .ifu_imem_addr  (ifu_imem_addr),
    .imem_ifu_rdata (imem_ifu_rdata),
    .idu_ifu_rdy    (idu_ifu_rdy),
    .idu_ifu_wfi    (idu_ifu_wfi),
    .ifu_idu_vld    (ifu_idu_vld),
    .ifu_idu_ins    (ifu_idu_ins),
    .ifu_busy       (ifu_busy),
    .ifu_done       (ifu_done)
  );

  always #5 clk = ~clk;

  // SRAM contents: word address in the low half, its complement in the high half.
  function automatic logic [INS_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {~{20'd0, a}, {20'd0, a}};
  endfunction

  // One-cycle read latency SRAM.
  always_ff @(posedge clk) begin
    if (ifu_imem_req) imem_ifu_rdata <= mem_word(ifu_imem_addr);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: addresses issued but not yet consumed, in order.
  logic [ADDR_W-1:0] q_addr [$];
  logic [ADDR_W-1:0] exp_issue;
  logic [ADDR_W-1:0] wfi_addr;
  logic [ADDR_W-1:0] last_del;
  logic              wfi_armed;
  logic              wfi_seen;
  int                delivered;
  int                cyc;
  int                first_req;
  int                first_vld;
  logic              last_req;
  logic              last_vld;

  // Sample one cycle at the falling edge, update the model, then advance.
  task automatic tick();
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    last_req = ifu_imem_req;
    last_vld = ifu_idu_vld;
    if (!rst) begin
      if (wfi_seen) begin
        chk("vld_after_wfi", ifu_idu_vld, 0);
      end else if (ifu_idu_vld && idu_ifu_rdy) begin
        if (q_addr.size() == 0) begin
          chk("deliver_unissued", ifu_idu_vld, 0);
        end else begin
          a = q_addr.pop_front();
          chk("ins", ifu_idu_ins, mem_word(a));
          delivered++;
          last_del = a;
          if (wfi_armed && a == wfi_addr) wfi_seen = 1'b1;
        end
      end
      if (ifu_idu_vld && first_vld < 0) first_vld = cyc;
      if (idu_ifu_wfi) chk("req_during_wfi", ifu_imem_req, 0);
      if (ifu_imem_req) begin
        if (first_req < 0) first_req = cyc;
        chk("issue_addr", ifu_imem_addr, exp_issue);
        q_addr.push_back(ifu_imem_addr);
        exp_issue = exp_issue + 12'd1;
        chk("outstanding_le_depth", (q_addr.size() <= DEPTH), 1);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    if (wfi_seen) idu_ifu_wfi = 1'b1;
  endtask

  task automatic model_reset(input logic [ADDR_W-1:0] pc, input logic arm, input logic [ADDR_W-1:0] wa);
    q_addr.delete();
    exp_issue = pc;
    wfi_addr  = wa;
    wfi_armed = arm;
    wfi_seen  = 1'b0;
    delivered = 0;
    cyc       = 0;
    first_req = -1;
    first_vld = -1;
  endtask

  // One fetch run from start_pc until the IDU's WFI at pc+k drives DONE.
  task automatic run_vec(input logic [ADDR_W-1:0] pc, input int k, input int mode,
                         input logic [ADDR_W-1:0] exp_last, input int exp_n);
    int budget;
    model_reset(pc, 1'b1, pc + ADDR_W'(k));
    idu_ifu_wfi = 1'b0;
    idu_ifu_rdy = 1'b1;
    start_pc    = pc;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    budget      = 0;
    while (!ifu_done && budget < 300) begin
      case (mode)
        M_RAND:  idu_ifu_rdy = 1'($urandom_range(0, 1));
        M_STALL: idu_ifu_rdy = (cyc >= 6 && cyc < 11) ? 1'b0 : 1'b1;
        default: idu_ifu_rdy = 1'b1;
      endcase
      tick();
      budget++;
      if (mode == M_STALL && cyc == 11) begin
        chk("stall_req_low", last_req, 0);
        chk("stall_vld_held", last_vld, 1);
      end
    end
    chk("done_reached", ifu_done, 1);
    chk("busy_after_wfi", ifu_busy, 0);
    chk("first_req_latency", 32'(first_req), 1);
    chk("first_vld_latency", 32'(first_vld), 3);
    chk("delivered_count", 32'(delivered), 32'(exp_n));
    chk("last_delivered", last_del, exp_last);
    idu_ifu_rdy = 1'b1;
    repeat (2) tick();
    chk("done_held", ifu_done, 1);
    chk("vld_in_done", last_vld, 0);
    chk("req_in_done", last_req, 0);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] pc;
    int                k;
    int                mode;
    logic [ADDR_W-1:0] exp_last;
    int                exp_n;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{12'h010, 3,  M_ALL,   12'h013, 4};
    tbl[1] = '{12'h100, 20, M_STALL, 12'h114, 21};
    tbl[2] = '{12'hFFE, 4,  M_ALL,   12'h002, 5};
    tbl[3] = '{12'h7F0, 10, M_RAND,  12'h7FA, 11};
    tbl[4] = '{12'hFFF, 0,  M_RAND,  12'hFFF, 1};

    rst = 1'b1; start = 1'b0; start_pc = '0;
    idu_ifu_rdy = 1'b0; idu_ifu_wfi = 1'b0;
    model_reset('0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", ifu_imem_req, 0);
    chk("rst_addr", ifu_imem_addr, 0);
    chk("rst_vld", ifu_idu_vld, 0);
    chk("rst_ins", ifu_idu_ins, 0);
    chk("rst_busy", ifu_busy, 0);
    chk("rst_done", ifu_done, 0);
    rst = 1'b0;

    // Start while fetching must not disturb the sequential stream.
    model_reset(12'h200, 1'b0, '0);
    idu_ifu_rdy = 1'b1;
    start_pc = 12'h200; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start_pc = 12'h300; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("start_in_fetch_busy", ifu_busy, 1);
    chk("start_in_fetch_pc", ifu_imem_addr, exp_issue);

    // Reset mid-stream with a read in flight: nothing may leak out afterwards.
    idu_ifu_rdy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_req", ifu_imem_req, 0);
    chk("midrst_addr", ifu_imem_addr, 0);
    chk("midrst_vld", ifu_idu_vld, 0);
    chk("midrst_ins", ifu_idu_ins, 0);
    chk("midrst_busy", ifu_busy, 0);
    chk("midrst_done", ifu_done, 0);
    model_reset('0, 1'b0, '0);
    idu_ifu_rdy = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_vld", last_vld, 0);
      chk("post_rst_req", last_req, 0);
    end

    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i].pc, tbl[i].k, tbl[i].mode, tbl[i].exp_last, tbl[i].exp_n);
    end

    for (int i = 0; i < 6; i++) begin
      logic [ADDR_W-1:0] rpc;
      int rk;
      rpc = ADDR_W'($urandom_range(0, 4095));
      rk  = int'($urandom_range(0, 25));
      run_vec(rpc, rk, M_RAND, rpc + ADDR_W'(rk), rk + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
